// File: rtl/pcie_dllp_pkg.sv
// PCIe DLLP constants, entry type, collector states and the
// transmitted-order DLLP CRC-16 helper.
package pcie_dllp_pkg;

   localparam int          DLLP_LEN      = 6;
   localparam logic [15:0] DLLP_CRC_POLY = 16'h100B;
   localparam logic [15:0] DLLP_CRC_SEED = 16'hFFFF;

   typedef enum logic {
      COL_IDLE,
      COL_COLLECT
   } col_state_t;

   typedef struct packed {
      logic [31:0] data;
      logic [15:0] crc;
   } dllp_entry_t;

   function automatic logic [15:0] dllp_crc16(input logic [31:0] data);
      logic [15:0] c;
      logic [15:0] r;
      logic [7:0]  b;
      logic        fb;
      c = DLLP_CRC_SEED;
      r = '0;
      for (int k = 0; k < 4; k++) begin
         b = data[8*(3-k) +: 8];
         for (int j = 0; j < 8; j++) begin
            fb = c[15] ^ b[j];
            c  = {c[14:0], 1'b0};
            if (fb)
               c = c ^ DLLP_CRC_POLY;
         end
      end
      c = ~c;
      // CRC bit 15 goes out first, so it lands in bit 0 of byte 4
      for (int j = 0; j < 8; j++) begin
         r[8+j] = c[15-j];
         r[j]   = c[7-j];
      end
      return r;
   endfunction

endpackage

// File: rtl/lpif_rx_dllp_extractor_if.sv
// LPIF receive byte stream in, DLLP valid/ready stream out.
// master: the extractor side; slave: PHY driver plus link layer.
interface lpif_rx_dllp_extractor_if #(
   parameter int NBYTES = 64
);

   logic [NBYTES-1:0]   pl_valid;
   logic [8*NBYTES-1:0] pl_data;
   logic [NBYTES-1:0]   pl_dllpstart;
   logic [NBYTES-1:0]   pl_dllpend;

   logic        dllp_valid;
   logic        dllp_ready;
   logic [31:0] dllp_data;
   logic [15:0] dllp_crc;
   logic        dllp_crc_ok;

   modport master (
      input  pl_valid,
      input  pl_data,
      input  pl_dllpstart,
      input  pl_dllpend,
      input  dllp_ready,
      output dllp_valid,
      output dllp_data,
      output dllp_crc,
      output dllp_crc_ok
   );

   modport slave (
      output pl_valid,
      output pl_data,
      output pl_dllpstart,
      output pl_dllpend,
      output dllp_ready,
      input  dllp_valid,
      input  dllp_data,
      input  dllp_crc,
      input  dllp_crc_ok
   );

endinterface

// File: rtl/dllp_rx_fifo.sv
// Show-ahead DLLP FIFO: up to MAX_WR writes and one read per cycle.
// The writer guarantees it never writes beyond DEPTH - level.
module dllp_rx_fifo
   import pcie_dllp_pkg::*;
#(
   parameter  int DEPTH  = 8,
   parameter  int MAX_WR = 2,
   localparam int AW     = $clog2(DEPTH),
   localparam int LW     = AW + 1,
   localparam int CW     = $clog2(MAX_WR) + 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [CW-1:0] wr_cnt,
   input  dllp_entry_t wr_data [MAX_WR],
   input  logic        rd_en,
   output dllp_entry_t rd_data,
   output logic        empty,
   output logic [LW-1:0] level
);

   dllp_entry_t   mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;

   always_ff @(posedge clk) begin
      for (int k = 0; k < MAX_WR; k++) begin
         if (k < int'(wr_cnt))
            mem[wptr + AW'(k)] <= wr_data[k];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr  <= '0;
         rptr  <= '0;
         level <= '0;
      end else begin
         wptr  <= wptr + AW'(wr_cnt);
         rptr  <= rptr + AW'(rd_en);
         level <= level + LW'(wr_cnt) - LW'(rd_en);
      end
   end

   assign rd_data = mem[rptr];
   assign empty   = (level == '0);

endmodule

// File: rtl/lpif_rx_dllp_extractor.sv
// Reassembles 6-byte DLLPs from the LPIF RX byte stream, queues
// them and presents one per cycle with a CRC-16 check result.
module lpif_rx_dllp_extractor
   import pcie_dllp_pkg::*;
#(
   parameter  int NBYTES        = 64,
   parameter  int MAX_PER_CYCLE = 2,
   parameter  int FIFO_DEPTH    = 8,
   localparam int LW            = $clog2(FIFO_DEPTH) + 1,
   localparam int CW            = $clog2(MAX_PER_CYCLE) + 1
) (
   input  logic                     clk,
   input  logic                     reset,
   lpif_rx_dllp_extractor_if.master bus,
   output logic                     malformed_pulse,
   output logic                     overflow_pulse,
   output logic [LW-1:0]            fifo_level
);

   localparam logic [2:0] LAST = 3'(DLLP_LEN - 1);

   col_state_t  st, st_n;
   logic [2:0]  cnt, cnt_n;
   logic [47:0] shreg, shreg_n;

   dllp_entry_t comp [MAX_PER_CYCLE];
   int          ncomp;
   logic        mal;
   logic [7:0]  b;
   logic        sb;
   logic        eb;

   int          cap;
   int          lim;
   int          nwr;
   logic        ovf;
   logic [CW-1:0] wr_cnt;

   dllp_entry_t head;
   logic        empty;
   logic        load;

   always_comb begin
      st_n    = st;
      cnt_n   = cnt;
      shreg_n = shreg;
      ncomp   = 0;
      mal     = 1'b0;
      b       = '0;
      sb      = 1'b0;
      eb      = 1'b0;
      for (int k = 0; k < MAX_PER_CYCLE; k++)
         comp[k] = '0;
      for (int i = 0; i < NBYTES; i++) begin
         if (bus.pl_valid[i]) begin
            b  = bus.pl_data[8*i +: 8];
            sb = bus.pl_dllpstart[i];
            eb = bus.pl_dllpend[i];
            unique case (st_n)
               COL_IDLE: begin
                  if (sb && !eb) begin
                     st_n    = COL_COLLECT;
                     cnt_n   = 3'd1;
                     shreg_n = {40'b0, b};
                  end else if (eb) begin
                     mal = 1'b1;
                  end
               end
               COL_COLLECT: begin
                  if (sb) begin
                     mal = 1'b1;
                     if (eb) begin
                        st_n  = COL_IDLE;
                        cnt_n = 3'd0;
                     end else begin
                        cnt_n   = 3'd1;
                        shreg_n = {40'b0, b};
                     end
                  end else if (eb) begin
                     if (cnt_n == LAST) begin
                        shreg_n = {shreg_n[39:0], b};
                        // later completions past the limit are only counted
                        for (int k = 0; k < MAX_PER_CYCLE; k++)
                           if (ncomp == k)
                              comp[k] = shreg_n;
                        ncomp = ncomp + 1;
                     end else begin
                        mal = 1'b1;
                     end
                     st_n  = COL_IDLE;
                     cnt_n = 3'd0;
                  end else if (cnt_n == LAST) begin
                     mal   = 1'b1;
                     st_n  = COL_IDLE;
                     cnt_n = 3'd0;
                  end else begin
                     shreg_n = {shreg_n[39:0], b};
                     cnt_n   = cnt_n + 3'd1;
                  end
               end
            endcase
         end
      end
   end

   // space freed by a pop this cycle is not usable until next cycle
   always_comb begin
      cap    = FIFO_DEPTH - int'(fifo_level);
      lim    = (cap < MAX_PER_CYCLE) ? cap : MAX_PER_CYCLE;
      nwr    = (ncomp < lim) ? ncomp : lim;
      ovf    = (ncomp > nwr);
      wr_cnt = CW'(nwr);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st              <= COL_IDLE;
         cnt             <= 3'd0;
         shreg           <= '0;
         malformed_pulse <= 1'b0;
         overflow_pulse  <= 1'b0;
      end else begin
         st              <= st_n;
         cnt             <= cnt_n;
         shreg           <= shreg_n;
         malformed_pulse <= mal;
         overflow_pulse  <= ovf;
      end
   end

   dllp_rx_fifo #(
      .DEPTH  (FIFO_DEPTH),
      .MAX_WR (MAX_PER_CYCLE)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_cnt  (wr_cnt),
      .wr_data (comp),
      .rd_en   (load),
      .rd_data (head),
      .empty   (empty),
      .level   (fifo_level)
   );

   assign load = !empty && (!bus.dllp_valid || bus.dllp_ready);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.dllp_valid  <= 1'b0;
         bus.dllp_data   <= '0;
         bus.dllp_crc    <= '0;
         bus.dllp_crc_ok <= 1'b0;
      end else if (load) begin
         bus.dllp_valid  <= 1'b1;
         bus.dllp_data   <= head.data;
         bus.dllp_crc    <= head.crc;
         bus.dllp_crc_ok <= (dllp_crc16(head.data) == head.crc);
      end else if (bus.dllp_ready) begin
         bus.dllp_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_lpif_rx_dllp_extractor.sv
// Directed bench for lpif_rx_dllp_extractor: framing, CRC,
// overflow and asynchronous reset on the LPIF byte stream.
module tb_lpif_rx_dllp_extractor;

   localparam int NB = 64;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       malformed_pulse;
   logic       overflow_pulse;
   logic [3:0] fifo_level;
   int         chk = 0;
   int         pass = 0;

   lpif_rx_dllp_extractor_if #(.NBYTES(NB)) bus ();

   lpif_rx_dllp_extractor #(
      .NBYTES        (NB),
      .MAX_PER_CYCLE (2),
      .FIFO_DEPTH    (8)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .bus             (bus),
      .malformed_pulse (malformed_pulse),
      .overflow_pulse  (overflow_pulse),
      .fifo_level      (fifo_level)
   );

   always #5 clk = ~clk;

   // reflected-register form of the DLLP CRC, mapped to {byte4, byte5}
   function automatic logic [15:0] ref_crc(input logic [31:0] d);
      logic [15:0] r;
      logic [7:0]  b;
      logic        fb;
      r = 16'hFFFF;
      for (int k = 0; k < 4; k++) begin
         b = d[31-8*k -: 8];
         for (int j = 0; j < 8; j++) begin
            fb = r[0] ^ b[j];
            r  = r >> 1;
            if (fb)
               r = r ^ 16'hD008;
         end
      end
      return {~r[7:0], ~r[15:8]};
   endfunction

   task automatic clr();
      bus.pl_valid     = '0;
      bus.pl_data      = '0;
      bus.pl_dllpstart = '0;
      bus.pl_dllpend   = '0;
   endtask

   task automatic put(input int lane, input logic [7:0] v,
                      input logic s, input logic e);
      bus.pl_valid[lane]      = 1'b1;
      bus.pl_data[8*lane +: 8] = v;
      bus.pl_dllpstart[lane]  = s;
      bus.pl_dllpend[lane]    = e;
   endtask

   task automatic put_dllp(input int lane, input logic [31:0] d,
                           input logic [15:0] c);
      logic [47:0] w;
      w = {d, c};
      for (int k = 0; k < 6; k++)
         put(lane + k, w[47-8*k -: 8], k == 0, k == 5);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic test_reset();
      bus.dllp_ready = 1'b1;
      clr();
      #2 reset = 1'b0;
      repeat (2) @(posedge clk);
      smp();
      chk++; if (bus.dllp_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", bus.dllp_valid); else pass++;
      chk++; if (bus.dllp_data !== 32'h0) $display("FAIL rst_data: got %h want 0", bus.dllp_data); else pass++;
      chk++; if (bus.dllp_crc !== 16'h0) $display("FAIL rst_crc: got %h want 0", bus.dllp_crc); else pass++;
      chk++; if (bus.dllp_crc_ok !== 1'b0) $display("FAIL rst_crc_ok: got %b want 0", bus.dllp_crc_ok); else pass++;
      chk++; if (malformed_pulse !== 1'b0) $display("FAIL rst_mal: got %b want 0", malformed_pulse); else pass++;
      chk++; if (overflow_pulse !== 1'b0) $display("FAIL rst_ovf: got %b want 0", overflow_pulse); else pass++;
      chk++; if (fifo_level !== 4'd0) $display("FAIL rst_level: got %0d want 0", fifo_level); else pass++;
      reset = 1'b1;
   endtask

   task automatic test_single();
      logic [31:0] d;
      logic [15:0] c;
      d = 32'h0A1B2C3D;
      c = ref_crc(d);
      tick(); clr(); put_dllp(0, d, c);
      tick(); clr(); smp();
      chk++; if (bus.dllp_valid !== 1'b0) $display("FAIL single_n1_valid: got %b want 0", bus.dllp_valid); else pass++;
      chk++; if (fifo_level !== 4'd1) $display("FAIL single_n1_level: got %0d want 1", fifo_level); else pass++;
      chk++; if (malformed_pulse !== 1'b0) $display("FAIL single_mal: got %b want 0", malformed_pulse); else pass++;
      chk++; if (overflow_pulse !== 1'b0) $display("FAIL single_ovf: got %b want 0", overflow_pulse); else pass++;
      tick(); smp();
      chk++; if (bus.dllp_valid !== 1'b1) $display("FAIL single_n2_valid: got %b want 1", bus.dllp_valid); else pass++;
      chk++; if (bus.dllp_data !== d) $display("FAIL single_data: got %h want %h", bus.dllp_data, d); else pass++;
      chk++; if (bus.dllp_crc !== c) $display("FAIL single_crc: got %h want %h", bus.dllp_crc, c); else pass++;
      chk++; if (bus.dllp_crc_ok !== 1'b1) $display("FAIL single_crc_ok: got %b want 1", bus.dllp_crc_ok); else pass++;
      tick(); smp();
      chk++; if (bus.dllp_valid !== 1'b0) $display("FAIL single_n3_valid: got %b want 0", bus.dllp_valid); else pass++;
   endtask

   task automatic test_split();
      logic [31:0] d;
      logic [15:0] c;
      d = 32'h11223344;
      c = ref_crc(d);
      tick(); clr();
      put(60, d[31:24], 1'b1, 1'b0);
      put(61, d[23:16], 1'b0, 1'b0);
      put(62, d[15:8], 1'b0, 1'b0);
      put(63, d[7:0], 1'b0, 1'b0);
      tick(); clr();
      put(0, c[15:8], 1'b0, 1'b0);
      put(1, c[7:0], 1'b0, 1'b1);
      bus.pl_dllpstart[2] = 1'b1;
      bus.pl_dllpend[3]   = 1'b1;
      smp();
      chk++; if (fifo_level !== 4'd0) $display("FAIL split_n1_level: got %0d want 0", fifo_level); else pass++;
      tick(); clr(); smp();
      chk++; if (bus.dllp_valid !== 1'b0) $display("FAIL split_n2_valid: got %b want 0", bus.dllp_valid); else pass++;
      chk++; if (malformed_pulse !== 1'b0) $display("FAIL split_mal: got %b want 0", malformed_pulse); else pass++;
      chk++; if (fifo_level !== 4'd1) $display("FAIL split_n2_level: got %0d want 1", fifo_level); else pass++;
      tick(); smp();
      chk++; if (bus.dllp_valid !== 1'b1) $display("FAIL split_n3_valid: got %b want 1", bus.dllp_valid); else pass++;
      chk++; if (bus.dllp_data !== d) $display("FAIL split_data: got %h want %h", bus.dllp_data, d); else pass++;
      chk++; if (bus.dllp_crc_ok !== 1'b1) $display("FAIL split_crc_ok: got %b want 1", bus.dllp_crc_ok); else pass++;
      tick(); smp();
   endtask

   task automatic test_back_to_back();
      logic [31:0] da, db;
      logic [15:0] ca, cb;
      da = 32'hA5A50001;
      db = 32'h5A5A0002;
      ca = ref_crc(da);
      cb = ref_crc(db) ^ 16'h0004;
      tick(); clr(); put_dllp(0, da, ca); put_dllp(10, db, cb);
      tick(); clr(); smp();
      chk++; if (fifo_level !== 4'd2) $display("FAIL b2b_level: got %0d want 2", fifo_level); else pass++;
      tick(); smp();
      chk++; if (bus.dllp_valid !== 1'b1) $display("FAIL b2b_a_valid: got %b want 1", bus.dllp_valid); else pass++;
      chk++; if (bus.dllp_data !== da) $display("FAIL b2b_a_data: got %h want %h", bus.dllp_data, da); else pass++;
      chk++; if (bus.dllp_crc_ok !== 1'b1) $display("FAIL b2b_a_ok: got %b want 1", bus.dllp_crc_ok); else pass++;
      tick(); smp();
      chk++; if (bus.dllp_valid !== 1'b1) $display("FAIL b2b_b_valid: got %b want 1", bus.dllp_valid); else pass++;
      chk++; if (bus.dllp_data !== db) $display("FAIL b2b_b_data: got %h want %h", bus.dllp_data, db); else pass++;
      chk++; if (bus.dllp_crc !== cb) $display("FAIL b2b_b_crc: got %h want %h", bus.dllp_crc, cb); else pass++;
      chk++; if (bus.dllp_crc_ok !== 1'b0) $display("FAIL b2b_b_ok: got %b want 0", bus.dllp_crc_ok); else pass++;
      tick(); smp();
      chk++; if (bus.dllp_valid !== 1'b0) $display("FAIL b2b_end_valid: got %b want 0", bus.dllp_valid); else pass++;
      chk++; if (fifo_level !== 4'd0) $display("FAIL b2b_end_level: got %0d want 0", fifo_level); else pass++;
   endtask

   task automatic test_malformed();
      logic [31:0] d;
      logic [15:0] c;
      for (int m = 0; m < 3; m++) begin
         tick(); clr();
         if (m == 0) begin
            put(0, 8'h01, 1'b1, 1'b0); put(1, 8'h02, 1'b0, 1'b0);
            put(2, 8'h03, 1'b0, 1'b0); put(3, 8'h04, 1'b0, 1'b1);
         end else if (m == 1) begin
            put(0, 8'h11, 1'b1, 1'b0); put(1, 8'h12, 1'b0, 1'b0);
            put(2, 8'h13, 1'b1, 1'b0); put(3, 8'h14, 1'b0, 1'b1);
         end else begin
            put(5, 8'h21, 1'b1, 1'b1);
         end
         tick(); clr(); smp();
         chk++; if (malformed_pulse !== 1'b1) $display("FAIL mal%0d_pulse: got %b want 1", m, malformed_pulse); else pass++;
         tick(); smp();
         chk++; if (malformed_pulse !== 1'b0) $display("FAIL mal%0d_pulse_end: got %b want 0", m, malformed_pulse); else pass++;
         chk++; if (fifo_level !== 4'd0) $display("FAIL mal%0d_level: got %0d want 0", m, fifo_level); else pass++;
         chk++; if (bus.dllp_valid !== 1'b0) $display("FAIL mal%0d_valid: got %b want 0", m, bus.dllp_valid); else pass++;
      end
      d = 32'hDEADBEEF;
      c = ref_crc(d);
      tick(); clr(); put(0, 8'hEE, 1'b1, 1'b0); put_dllp(1, d, c);
      tick(); clr(); smp();
      chk++; if (malformed_pulse !== 1'b1) $display("FAIL restart_pulse: got %b want 1", malformed_pulse); else pass++;
      chk++; if (fifo_level !== 4'd1) $display("FAIL restart_level: got %0d want 1", fifo_level); else pass++;
      tick(); smp();
      chk++; if (bus.dllp_data !== d) $display("FAIL restart_data: got %h want %h", bus.dllp_data, d); else pass++;
      chk++; if (bus.dllp_crc_ok !== 1'b1) $display("FAIL restart_ok: got %b want 1", bus.dllp_crc_ok); else pass++;
      tick(); smp();
   endtask

   task automatic test_overflow();
      int          lvl [6];
      logic [31:0] d;
      lvl = '{0, 2, 3, 5, 7, 8};
      bus.dllp_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick(); clr();
         d = 32'hC0000000 + 32'(2*i);
         put_dllp(0, d, ref_crc(d));
         put_dllp(6, d + 1, ref_crc(d + 1));
         smp();
         chk++; if (fifo_level !== 4'(lvl[i])) $display("FAIL ovf_c%0d_level: got %0d want %0d", i, fifo_level, lvl[i]); else pass++;
         chk++; if (overflow_pulse !== 1'b0) $display("FAIL ovf_c%0d_pulse: got %b want 0", i, overflow_pulse); else pass++;
      end
      tick(); clr(); smp();
      chk++; if (fifo_level !== 4'd8) $display("FAIL ovf_c5_level: got %0d want 8", fifo_level); else pass++;
      chk++; if (overflow_pulse !== 1'b1) $display("FAIL ovf_c5_pulse: got %b want 1", overflow_pulse); else pass++;
      chk++; if (bus.dllp_data !== 32'hC0000000) $display("FAIL ovf_hold_data: got %h want c0000000", bus.dllp_data); else pass++;
      tick(); smp();
      chk++; if (overflow_pulse !== 1'b0) $display("FAIL ovf_c6_pulse: got %b want 0", overflow_pulse); else pass++;
      chk++; if (fifo_level !== 4'd8) $display("FAIL ovf_c6_level: got %0d want 8", fifo_level); else pass++;
      chk++; if (bus.dllp_valid !== 1'b1) $display("FAIL ovf_c6_valid: got %b want 1", bus.dllp_valid); else pass++;
      bus.dllp_ready = 1'b1;
      for (int i = 1; i < 9; i++) begin
         tick(); smp();
         d = 32'hC0000000 + 32'(i);
         chk++; if (bus.dllp_valid !== 1'b1 || bus.dllp_data !== d) $display("FAIL drain%0d: got %b/%h want 1/%h", i, bus.dllp_valid, bus.dllp_data, d); else pass++;
      end
      chk++; if (bus.dllp_crc_ok !== 1'b1) $display("FAIL drain_ok: got %b want 1", bus.dllp_crc_ok); else pass++;
      tick(); smp();
      chk++; if (bus.dllp_valid !== 1'b0) $display("FAIL drain_end_valid: got %b want 0", bus.dllp_valid); else pass++;
      chk++; if (fifo_level !== 4'd0) $display("FAIL drain_end_level: got %0d want 0", fifo_level); else pass++;
      tick(); clr();
      for (int i = 0; i < 3; i++) begin
         d = 32'hE0000000 + 32'(i);
         put_dllp(6*i, d, ref_crc(d));
      end
      tick(); clr(); smp();
      chk++; if (overflow_pulse !== 1'b1) $display("FAIL three_pulse: got %b want 1", overflow_pulse); else pass++;
      chk++; if (fifo_level !== 4'd2) $display("FAIL three_level: got %0d want 2", fifo_level); else pass++;
      tick(); smp();
      chk++; if (bus.dllp_data !== 32'hE0000000) $display("FAIL three_d0: got %h want e0000000", bus.dllp_data); else pass++;
      tick(); smp();
      chk++; if (bus.dllp_data !== 32'hE0000001) $display("FAIL three_d1: got %h want e0000001", bus.dllp_data); else pass++;
      tick(); smp();
      chk++; if (bus.dllp_valid !== 1'b0) $display("FAIL three_end_valid: got %b want 0", bus.dllp_valid); else pass++;
   endtask

   task automatic test_reset_mid();
      logic [31:0] d;
      logic [15:0] c;
      bus.dllp_ready = 1'b0;
      tick(); clr();
      put_dllp(0, 32'h0B000000, ref_crc(32'h0B000000));
      put_dllp(6, 32'h0B000001, ref_crc(32'h0B000001));
      tick(); clr();
      put_dllp(0, 32'h0B000002, ref_crc(32'h0B000002));
      put(20, 8'h77, 1'b1, 1'b0);
      put(21, 8'h78, 1'b0, 1'b0);
      tick(); clr(); smp();
      chk++; if (fifo_level !== 4'd2) $display("FAIL rmid_pre_level: got %0d want 2", fifo_level); else pass++;
      chk++; if (bus.dllp_valid !== 1'b1) $display("FAIL rmid_pre_valid: got %b want 1", bus.dllp_valid); else pass++;
      reset = 1'b0;
      #1;
      chk++; if (bus.dllp_valid !== 1'b0) $display("FAIL rmid_valid: got %b want 0", bus.dllp_valid); else pass++;
      chk++; if (fifo_level !== 4'd0) $display("FAIL rmid_level: got %0d want 0", fifo_level); else pass++;
      chk++; if (bus.dllp_data !== 32'h0) $display("FAIL rmid_data: got %h want 0", bus.dllp_data); else pass++;
      chk++; if (bus.dllp_crc !== 16'h0) $display("FAIL rmid_crc: got %h want 0", bus.dllp_crc); else pass++;
      @(negedge clk);
      reset = 1'b1;
      bus.dllp_ready = 1'b1;
      d = 32'h600DF00D;
      c = ref_crc(d);
      tick(); clr(); put_dllp(0, d, c);
      tick(); clr(); smp();
      chk++; if (malformed_pulse !== 1'b0) $display("FAIL rmid_new_mal: got %b want 0", malformed_pulse); else pass++;
      chk++; if (fifo_level !== 4'd1) $display("FAIL rmid_new_level: got %0d want 1", fifo_level); else pass++;
      tick(); smp();
      chk++; if (bus.dllp_data !== d) $display("FAIL rmid_new_data: got %h want %h", bus.dllp_data, d); else pass++;
      chk++; if (bus.dllp_crc_ok !== 1'b1) $display("FAIL rmid_new_ok: got %b want 1", bus.dllp_crc_ok); else pass++;
      tick(); smp();
      chk++; if (bus.dllp_valid !== 1'b0) $display("FAIL rmid_end_valid: got %b want 0", bus.dllp_valid); else pass++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_split();
      test_back_to_back();
      test_malformed();
      test_overflow();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass, chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

endmodule

// File: doc/lpif_rx_dllp_extractor.md
# lpif_rx_dllp_extractor

Consumes the byte-flagged LPIF receive stream (`pl_data`, `pl_valid`, `pl_dllpstart`, `pl_dllpend`) leaving the RX physical-layer top and directly feeds the data link layer. It reassembles 6-byte DLLPs, which may span clock cycles and may be packed several per cycle. It buffers the DLLPs in a small FIFO and presents them one per cycle on a valid/ready interface, each with a CRC-16 check result. TLP bytes are ignored.

## Interface
- `NBYTES`, 64: LPIF byte lanes; byte i = `pl_data[8i+:8]`, flags bit i.
- `MAX_PER_CYCLE`, 2: DLLP completions accepted per input cycle.
- `FIFO_DEPTH`, 8: DLLP entries, power of 2, ≥ `MAX_PER_CYCLE`.

Ports:
- `clk` in 1: sole clock.
- `reset` in 1: asynchronous, active-low.
- `pl_valid` in NBYTES: per-byte valid.
- `pl_data` in 8*NBYTES: received bytes, framing already stripped.
- `pl_dllpstart` in NBYTES: first DLLP byte.
- `pl_dllpend` in NBYTES: last DLLP byte (second CRC byte).
- `dllp_valid` out 1: output entry valid.
- `dllp_ready` in 1: DLL accepts.
- `dllp_data` out 32: DLLP bytes 0..3; byte0 in [31:24].
- `dllp_crc` out 16: received bytes 4,5 as {byte4, byte5}.
- `dllp_crc_ok` out 1: computed CRC matches `dllp_crc`.
- `malformed_pulse` out 1: one-cycle pulse, framing/length error seen.
- `overflow_pulse` out 1: one-cycle pulse, DLLP(s) dropped, FIFO full or > `MAX_PER_CYCLE`.
- `fifo_level` out $clog2(FIFO_DEPTH)+1: entries in FIFO.

## Operation
- Bytes with `pl_valid`=0 are ignored entirely, including their flags. Valid bytes are scanned low index to high; state carries across cycles.
- Collector state is IDLE or COLLECT, with `cnt` 0..5 and a 48-bit assembly register.
- IDLE:
  - start and no end → COLLECT, `cnt`=1.
  - start and end on the same byte → malformed, stay IDLE.
  - end only → malformed.
  - other bytes are ignored.
- COLLECT, per valid byte:
  - start → malformed; discard the partial and restart with `cnt`=1.
  - end with `cnt`=5 → completion, IDLE.
  - end with `cnt`≠5 → malformed, IDLE.
  - neither flag with `cnt`=5 → malformed, IDLE.
  - otherwise append, `cnt`+1.
- Completions in one cycle are written to the FIFO in byte order, at most `MAX_PER_CYCLE`.
- FIFO capacity is `FIFO_DEPTH` − level at cycle start; a pop in the same cycle does not free space.
- Completions beyond the per-cycle limit or beyond capacity are dropped and `overflow_pulse` is raised.
- Multiple errors in one cycle produce a single pulse of each kind.
- Output stage is a register. It loads the FIFO head when FIFO is non-empty and (`dllp_valid`=0 or `dllp_ready`=1).
- CRC: computed on head bytes 0..3 at load time, per PCIe Base Spec 3.0 DLLP CRC:
  - polynomial 0x100B, seed 0xFFFF, bit 0 of each byte first;
  - result complemented and bit-mapped into transmitted bytes 4,5.
- `dllp_crc_ok` = match. Entries with a bad CRC are still delivered; the DLL discards them.
- Output holds stable while `dllp_valid`=1 and `dllp_ready`=0.

## Timing
- Reset values:
  - `dllp_valid`, `dllp_data`, `dllp_crc`, `dllp_crc_ok`, `malformed_pulse`, `overflow_pulse`, `fifo_level` = 0.
  - FIFO empty; collector IDLE, `cnt`=0.
- Reset asserted mid-packet or mid-handshake: partial DLLP and all FIFO contents are discarded immediately (asynchronous).
- DLLP whose end byte arrives in cycle N:
  - FIFO write at the edge ending N;
  - `dllp_valid` high in cycle N+2 at the earliest (FIFO empty, output free).
- Error pulses: condition in input cycle N → pulse high exactly in cycle N+1.
- Throughput: one DLLP per cycle with `dllp_ready` held high; no bubbles while the FIFO is non-empty.
- `fifo_level` is registered and reflects the writes and pops of the previous edge.

## Structure
- Package `pcie_dllp_pkg` holds:
  - `DLLP_LEN`=6, `DLLP_CRC_POLY`=16'h100B, `DLLP_CRC_SEED`=16'hFFFF;
  - typedef `dllp_entry_t` {data[31:0], crc[15:0]};
  - function `dllp_crc16(data[31:0])` returning the transmitted-order CRC.
- Sub-module `dllp_rx_fifo`: multi-write (≤ `MAX_PER_CYCLE` per cycle), single-read, show-ahead, with level output.
- Collector scan and output register live in the top module.

## Test plan
- Single DLLP, bytes 0..5 in one cycle, correct CRC, `dllp_ready`=1 → `dllp_valid` in N+2, `dllp_data`=byte0..3, `dllp_crc_ok`=1, no pulses.
- DLLP split across cycles: bytes 60..63 in cycle N, bytes 0..1 in N+1 → one entry with correct data; `dllp_valid` in N+3.
- Two DLLPs at bytes 0..5 and 10..15, one with a CRC bit flipped, `dllp_ready`=1 → two consecutive outputs with `dllp_crc_ok`=1 then 0.
- Malformed cases, each → `malformed_pulse` in the next cycle and nothing enqueued:
  - end at `cnt`=3;
  - start inside COLLECT;
  - start and end on the same byte.
- Overflow: `dllp_ready`=0, 5 cycles of 2 DLLPs each →
  - `fifo_level` saturates at 8;
  - `overflow_pulse` in cycle N+1 of each cycle whose DLLP(s) are dropped because the FIFO is full;
  - 3 DLLPs in one cycle → third dropped, pulse.
- Assert `reset` with 3 queued entries and a partial DLLP → all outputs 0 immediately; a new DLLP after release delivers correctly.
